unified_mem_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline.
- Arbitrates the two stages, sequences each fixed-latency memory access with a state machine, and drives the stall signals that hold the PC/IF_ID register (IF waiting) or freeze the whole pipeline (MEM waiting).
- Sits alongside the hazard detection unit; its stall outputs are ORed with the hazard stalls.

---
 rtl/unified_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter/sequencer sharing one fixed-latency single-port memory between IF and MEM.
// Optional stall-cycle counters are built when MEM_ARB_PERF_EN is defined.
module unified_mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ready,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [31:0]   if_wait_cnt,
  output logic [31:0]   mem_wait_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t        state_q, state_d;
  logic          owner_mem_q, owner_mem_d;
  logic          ram_en_q, ram_en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          abort_q, abort_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;
  logic          mem_req;

  assign mem_req = mem_rd | mem_wr;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    ram_en_d    = 1'b0;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    // A fetch whose requester drops out (branch flush) finishes silently.
    if (state_q != IDLE && !owner_mem_q && !if_req) abort_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (mem_req) begin
          owner_mem_d = 1'b1;
          addr_d      = mem_addr;
          wdata_d     = mem_wdata;
          we_d        = mem_wr;
          ram_en_d    = 1'b1;
          state_d     = ISSUE;
        end else if (if_req) begin
          owner_mem_d = 1'b0;
          addr_d      = if_addr;
          we_d        = 1'b0;
          ram_en_d    = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_mem_q)                mem_rdata_d = ram_rdata;
            else if (!(abort_q || !if_req)) if_rdata_d  = ram_rdata;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_mem_q <= 1'b0;
      ram_en_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      ram_en_q    <= ram_en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_ready  = (state_q == DONE) && !owner_mem_q && !abort_q;
  assign mem_ready = (state_q == DONE) && owner_mem_q;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = mem_req & ~mem_ready;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_en_q & we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_wait_q, if_wait_d, mem_wait_q, mem_wait_d;

  always_comb begin
    if_wait_d  = if_wait_q;
    mem_wait_d = mem_wait_q;
    if (stall_if  && if_wait_q  != '1) if_wait_d  = if_wait_q  + 32'd1;
    if (stall_mem && mem_wait_q != '1) mem_wait_d = mem_wait_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_wait_q  <= '0;
      mem_wait_q <= '0;
    end else begin
      if_wait_q  <= if_wait_d;
      mem_wait_q <= mem_wait_d;
    end
  end

  assign if_wait_cnt  = if_wait_q;
  assign mem_wait_cnt = mem_wait_q;
`else
  assign if_wait_cnt  = '0;
  assign mem_wait_cnt = '0;
`endif

`ifndef SYNTHESIS
  // Load and store together is a requester bug; such an access proceeds as a store.
  a_no_rd_and_wr: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_rd && mem_wr));
  a_mem_req_held: assert property (@(posedge clk) disable iff (!reset_n)
    (mem_req && !mem_ready) |=> mem_req);
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: stimulus pushes expected ready pulses into a
// scoreboard queue that a negedge monitor pops; inline checks cover strobes and stalls.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, mem_rd, mem_wr;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, if_wait_cnt, mem_wait_cnt;
  logic        if_ready, mem_ready, stall_if, stall_mem, ram_en, ram_we;

  unified_mem_arbiter #(.LATENCY(2), .AW(32), .DW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .if_wait_cnt(if_wait_cnt), .mem_wait_cnt(mem_wait_cnt)
  );

  always #5 clk = ~clk;

`ifdef MEM_ARB_PERF_EN
  localparam logic [31:0] EXP_IF_WAIT = 32'd9, EXP_MEM_WAIT = 32'd4;
`else
  localparam logic [31:0] EXP_IF_WAIT = 32'd0, EXP_MEM_WAIT = 32'd0;
`endif

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, t0 = 0;

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data appears exactly two cycles after the ram_en cycle, for one cycle.
  logic [31:0] ram_img [logic [31:0]];
  logic [1:0]  pipe_v = '0;
  logic [31:0] pipe_d0 = '0, pipe_d1 = '0;
  always @(posedge clk) begin
    if (ram_en && ram_we) ram_img[ram_addr] = ram_wdata;
    pipe_v  <= {pipe_v[0], ram_en && !ram_we};
    pipe_d0 <= ram_img.exists(ram_addr) ? ram_img[ram_addr] : 32'h0;
    pipe_d1 <= pipe_d0;
  end
  assign ram_rdata = pipe_v[1] ? pipe_d1 : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && (if_ready || mem_ready)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ready: if_ready=%0b mem_ready=%0b at cycle %0d, expected no pulse",
                 if_ready, mem_ready, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready_owner_is_mem", {31'd0, mem_ready}, {31'd0, e.is_mem});
        check("ready_both_high", {31'd0, if_ready & mem_ready}, 32'd0);
        check("ready_cycle", 32'(cyc), 32'(e.cyc));
        check("ready_data", mem_ready ? mem_rdata : if_rdata, e.data);
      end
    end
  end

  task automatic push(input bit is_mem, input logic [31:0] data, input int rel);
    exp_t e;
    e.is_mem = is_mem;
    e.data   = data;
    e.cyc    = t0 + rel;
    sb.push_back(e);
  endtask

  task automatic start();
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  task automatic drive_at(input int k);
    @(posedge clk);
    #1;
    while (cyc != t0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample_at(input int k);
    @(negedge clk);
    while (cyc != t0 + k) @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ram_img[32'h40]  = 32'h8C22_0004;
    ram_img[32'h44]  = 32'hAC43_0008;
    ram_img[32'h48]  = 32'h0123_4567;
    ram_img[32'h200] = 32'h1234_5678;
    reset_n = 1'b0;
    if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_if_wait_cnt", if_wait_cnt, 32'd0);
    check("rst_mem_wait_cnt", mem_wait_cnt, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous IF and MEM load: MEM first, IF granted after
    start();
    if_req = 1'b1; if_addr = 32'h44;
    mem_rd = 1'b1; mem_addr = 32'h200;
    push(1'b1, 32'h1234_5678, 4);
    push(1'b0, 32'hAC43_0008, 9);
    for (int k = 0; k <= 4; k++) begin
      sample_at(k);
      check($sformatf("s2_stall_mem_c%0d", k), {31'd0, stall_mem}, (k < 4) ? 32'd1 : 32'd0);
      check($sformatf("s2_stall_if_c%0d", k), {31'd0, stall_if}, 32'd1);
      if (k == 1) begin
        check("s2_ram_en_c1", {31'd0, ram_en}, 32'd1);
        check("s2_ram_addr_c1", ram_addr, 32'h200);
      end
    end
    drive_at(5);
    mem_rd = 1'b0;
    sample_at(6);
    check("s2_ram_en_c6", {31'd0, ram_en}, 32'd1);
    check("s2_ram_we_c6", {31'd0, ram_we}, 32'd0);
    check("s2_ram_addr_c6", ram_addr, 32'h44);
    drive_at(10);
    if_req = 1'b0;
    sample_at(10);
    check("s2_if_wait_cnt", if_wait_cnt, EXP_IF_WAIT);
    check("s2_mem_wait_cnt", mem_wait_cnt, EXP_MEM_WAIT);
    drain();

    // Single instruction fetch
    start();
    if_req = 1'b1; if_addr = 32'h40;
    push(1'b0, 32'h8C22_0004, 4);
    for (int k = 0; k <= 4; k++) begin
      sample_at(k);
      check($sformatf("s1_stall_if_c%0d", k), {31'd0, stall_if}, (k < 4) ? 32'd1 : 32'd0);
      check($sformatf("s1_ram_en_c%0d", k), {31'd0, ram_en}, (k == 1) ? 32'd1 : 32'd0);
      if (k == 1) begin
        check("s1_ram_we_c1", {31'd0, ram_we}, 32'd0);
        check("s1_ram_addr_c1", ram_addr, 32'h40);
      end
    end
    drive_at(5);
    if_req = 1'b0;
    drain();

    // Store: write strobe, completion pulse, load data register untouched
    start();
    mem_wr = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    push(1'b1, 32'h1234_5678, 4);
    sample_at(1);
    check("s3_ram_en", {31'd0, ram_en}, 32'd1);
    check("s3_ram_we", {31'd0, ram_we}, 32'd1);
    check("s3_ram_addr", ram_addr, 32'h100);
    check("s3_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    drive_at(5);
    mem_wr = 1'b0;
    sample_at(5);
    check("s3_mem_rdata_kept", mem_rdata, 32'h1234_5678);
    drain();

    // Branch flush: fetch of 0x40 abandoned, 0x44 re-requested mid-access
    ram_img[32'h40] = 32'h0BAD_F00D;
    start();
    if_req = 1'b1; if_addr = 32'h40;
    drive_at(2);
    if_req = 1'b0;
    drive_at(3);
    if_req = 1'b1; if_addr = 32'h44;
    push(1'b0, 32'hAC43_0008, 9);
    sample_at(4);
    check("s4_if_rdata_kept", if_rdata, 32'h8C22_0004);
    sample_at(6);
    check("s4_ram_en_c6", {31'd0, ram_en}, 32'd1);
    check("s4_ram_addr_c6", ram_addr, 32'h44);
    drive_at(10);
    if_req = 1'b0;
    drain();

    // Asynchronous reset in the middle of a fetch, request held throughout
    start();
    if_req = 1'b1; if_addr = 32'h48;
    drive_at(2);
    #2;
    reset_n = 1'b0;
    #1;
    check("s5_ram_en", {31'd0, ram_en}, 32'd0);
    check("s5_if_ready", {31'd0, if_ready}, 32'd0);
    check("s5_if_rdata", if_rdata, 32'd0);
    check("s5_mem_rdata", mem_rdata, 32'd0);
    check("s5_ram_addr", ram_addr, 32'd0);
    check("s5_stall_if", {31'd0, stall_if}, 32'd1);
    sample_at(3);
    reset_n = 1'b1;
    push(1'b0, 32'h0123_4567, 7);
    sample_at(4);
    check("s5_regrant_ram_en", {31'd0, ram_en}, 32'd1);
    check("s5_regrant_addr", ram_addr, 32'h48);
    drive_at(8);
    if_req = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
